mac_accum: RTL

Pipelined multiply-accumulate datapath stage for the matrix-multiply engine. It sits directly downstream of the matrix controller and the m1/m2 operand memories, and directly upstream of the m3 result memory. It consumes one operand pair per `ld` pulse, accumulates the dot product, and on `clr` emits the finished element with a scaled value, term count and overflow flag. It then restarts accumulation for the next element without losing an in-flight product.

---
 rtl/mac_pkg.sv | 11 +
 rtl/mac_mult_stage.sv | 46 ++++
 rtl/mac_accum.sv | 118 +++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: shared constants for the multiply-accumulate datapath.
//   DW_DEF    - default operand width
//   ACC_W_DEF - default accumulator / result width (must be >= 2*DW)
//   CNT_W_DEF - default accumulated-term counter width
//   SH_W      - width of the result right-shift control
package mac_pkg;
  localparam int DW_DEF    = 8;
  localparam int ACC_W_DEF = 20;
  localparam int CNT_W_DEF = 8;
  localparam int SH_W      = 2;
endpackage

// File: rtl/mac_mult_stage.sv
// mac_mult_stage: stage-1 registered multiplier.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   ld   - operand pair valid this cycle
//   a, b - unsigned operands (DW bits)
//   p_q  - registered product, zero-extended to ACC_W bits
//   p_v  - p_q holds a product loaded on the previous edge
module mac_mult_stage
  import mac_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  output logic [ACC_W-1:0] p_q,
  output logic             p_v
);

  logic [2*DW-1:0] prod;

  // Full-width unsigned product of the current operand pair.
  always_comb begin
    prod = a * b;
  end

  // Capture the product on ld; the valid flag follows ld every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_q <= {ACC_W{1'b0}};
      p_v <= 1'b0;
    end else begin
      p_v <= ld;
      if (ld) begin
        p_q <= ACC_W'(prod);
      end else begin
        p_q <= p_q;
      end
    end
  end

endmodule

// File: rtl/mac_accum.sv
// mac_accum: pipelined multiply-accumulate stage for the matrix-multiply engine.
// Build option: MAC_ACC_SAT_EN - when defined, an accumulator carry-out
// saturates the sum to all-ones; otherwise the sum wraps. The overflow flag
// is raised on carry-out in both builds.
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-low reset
//   ld        - operand pair valid this cycle
//   clr       - finish current element and restart accumulation
//   a, b      - unsigned operands (DW bits)
//   sh        - logical right shift applied to the result, sampled with clr
//   out_valid - one-cycle pulse, out_* fields valid
//   out_data  - finished (shifted) element
//   out_cnt   - number of products in out_data
//   out_ovf   - accumulator overflowed during this element
module mac_accum
  import mac_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             clr,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  input  logic [SH_W-1:0]  sh,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf
);

  logic [ACC_W-1:0] p_q;
  logic             p_v;

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic [ACC_W-1:0] addend;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic [ACC_W-1:0] fin;
  logic [CNT_W-1:0] cnt_next;

  mac_mult_stage #(
    .DW    (DW),
    .ACC_W (ACC_W)
  ) u_mult (
    .clk (clk),
    .rst (rst),
    .ld  (ld),
    .a   (a),
    .b   (b),
    .p_q (p_q),
    .p_v (p_v)
  );

  // Next accumulator value including any pending product, with the
  // overflow policy applied to the carry-out.
  always_comb begin
    if (p_v) begin
      addend = p_q;
    end else begin
      addend = {ACC_W{1'b0}};
    end
    sum      = {1'b0, acc} + {1'b0, addend};
    carry    = sum[ACC_W];
    cnt_next = cnt + CNT_W'(p_v);
`ifdef MAC_ACC_SAT_EN
    if (carry) begin
      fin = {ACC_W{1'b1}};
    end else begin
      fin = sum[ACC_W-1:0];
    end
`else
    fin = sum[ACC_W-1:0];
`endif
  end

  // Accumulate, and on clr emit the element while restarting from zero.
  // A product loaded in the clr cycle is still in stage 1, so it lands in
  // the next element automatically.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= {ACC_W{1'b0}};
      cnt       <= {CNT_W{1'b0}};
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= {ACC_W{1'b0}};
      out_cnt   <= {CNT_W{1'b0}};
      out_ovf   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (clr) begin
        out_data  <= fin >> sh;
        out_cnt   <= cnt_next;
        out_ovf   <= ovf | carry;
        out_valid <= 1'b1;
        acc       <= {ACC_W{1'b0}};
        cnt       <= {CNT_W{1'b0}};
        ovf       <= 1'b0;
      end else if (p_v) begin
        acc <= fin;
        cnt <= cnt_next;
        ovf <= ovf | carry;
      end else begin
        acc <= acc;
        cnt <= cnt;
        ovf <= ovf;
      end
    end
  end

endmodule
